// File: rtl/ctl_pkg.sv
// Shared definitions for the lap-counting sequencer.
//   estado_t      : FSM state encoding (IDLE=0, CARGA=1, CUENTA=2, PAUSA=3, FIN=4)
//   MODO_*        : counting mode codes; 2'b11 is treated as up
//   clogb2(v)     : number of bits needed to hold the value v (minimum 1)
package ctl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CARGA  = 3'd1,
        CUENTA = 3'd2,
        PAUSA  = 3'd3,
        FIN    = 3'd4
    } estado_t;

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_PP   = 2'b10;

    function automatic int clogb2(input int valor);
        int v;
        int n;
        v = valor;
        n = 0;
        while (v > 0) begin
            n = n + 1;
            v = v >> 1;
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/control_contador_vueltas_contador.sv
// Loadable modulo-MODULO up/down counter.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low
//   load     : load valor this cycle (overrides enable)
//   valor    : value to load
//   enable   : take one step in the direction given by up
//   up       : 1 = count up, 0 = count down
//   cuenta   : current count
//   terminal : cuenta is at the wrap point for the current direction
//              (MODULO-1 going up, 0 going down)
module contador_carga #(
    parameter int MODULO = 16,
    parameter int WC     = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [WC-1:0] valor,
    input  logic          enable,
    input  logic          up,
    output logic [WC-1:0] cuenta,
    output logic          terminal
);

    localparam logic [WC-1:0] MAX_C = WC'(MODULO - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (load) begin
            cuenta <= valor;
        end else if (enable) begin
            if (up) cuenta <= (cuenta == MAX_C) ? '0 : cuenta + 1'b1;
            else    cuenta <= (cuenta == '0) ? MAX_C : cuenta - 1'b1;
        end
    end

    assign terminal = up ? (cuenta == MAX_C) : (cuenta == '0);

endmodule

// File: rtl/control_contador_vueltas.sv
// Lap sequencer: on start, runs a modulo-MODULO counter for num_vueltas
// complete laps in up, down or ping-pong mode, with pause, abort and an
// external tick enable.
//
// Handshake: start is sampled only while idle (busy=0); a start seen there
// latches modo/num_vueltas and raises busy on the next cycle. busy stays high
// through the final cycle, in which done pulses for exactly one cycle. An
// abort returns to idle without a done pulse. A start level still high when
// idle is reached again begins a new run.
//
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-low reset
//   start           : start command
//   modo            : 00 up, 01 down, 10 ping-pong, 11 up
//   num_vueltas     : laps to run (0 finishes immediately after loading)
//   tick            : step enable
//   pausa           : hold everything while high
//   abort           : synchronous abort, highest priority after reset
//   busy, done      : run in progress / one-cycle completion pulse
//   cuenta, dir     : current count and direction (1 = up)
//   vuelta          : laps completed in the current or last run
//   fin_cuenta      : cuenta at the terminal value for dir
//   estado          : current FSM state (debug)
module control_contador_vueltas
    import ctl_pkg::*;
#(
    parameter int  MODULO      = 16,
    parameter int  MAX_VUELTAS = 255,
    localparam int WC          = clogb2(MODULO - 1),
    localparam int WV          = clogb2(MAX_VUELTAS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    modo,
    input  logic [WV-1:0] num_vueltas,
    input  logic          tick,
    input  logic          pausa,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [WC-1:0] cuenta,
    output logic          dir,
    output logic [WV-1:0] vuelta,
    output logic          fin_cuenta,
    output logic [2:0]    estado
);

    localparam logic [WC-1:0] MAX_C = WC'(MODULO - 1);

    estado_t       estado_q, estado_d;
    logic [1:0]    modo_q;
    logic [WV-1:0] vueltas_q;
    logic          dir_q, dir_d;
    logic [WV-1:0] vuelta_q, vuelta_d;
    logic [WV-1:0] vuelta_inc;
    logic          latch;
    logic          paso;
    logic          cnt_load;
    logic [WC-1:0] cnt_valor;
    logic          cnt_enable;
    logic          terminal;

    contador_carga #(
        .MODULO (MODULO),
        .WC     (WC)
    ) u_contador (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .valor    (cnt_valor),
        .enable   (cnt_enable),
        .up       (dir_q),
        .cuenta   (cuenta),
        .terminal (terminal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= IDLE;
            modo_q    <= '0;
            vueltas_q <= '0;
            dir_q     <= 1'b1;
            vuelta_q  <= '0;
        end else begin
            estado_q <= estado_d;
            dir_q    <= dir_d;
            vuelta_q <= vuelta_d;
            if (latch) begin
                modo_q    <= modo;
                vueltas_q <= num_vueltas;
            end
        end
    end

    assign vuelta_inc = vuelta_q + 1'b1;

    always_comb begin
        estado_d   = estado_q;
        dir_d      = dir_q;
        vuelta_d   = vuelta_q;
        latch      = 1'b0;
        paso       = 1'b0;
        cnt_load   = 1'b0;
        cnt_valor  = '0;
        cnt_enable = 1'b0;

        if (abort && estado_q != IDLE) begin
            // Everything freezes where it is; no done pulse.
            estado_d = IDLE;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (start) begin
                        estado_d = CARGA;
                        latch    = 1'b1;
                    end
                end
                CARGA: begin
                    cnt_load  = 1'b1;
                    cnt_valor = (modo_q == MODO_DOWN) ? MAX_C : '0;
                    dir_d     = (modo_q != MODO_DOWN);
                    vuelta_d  = '0;
                    estado_d  = (vueltas_q == '0) ? FIN : CUENTA;
                end
                CUENTA: begin
                    if (pausa) estado_d = PAUSA;
                    else       paso     = tick;
                end
                PAUSA: begin
                    // Leaving the pause can already step in the same cycle.
                    if (!pausa) begin
                        estado_d = CUENTA;
                        paso     = tick;
                    end
                end
                FIN: begin
                    estado_d = IDLE;
                end
                default: begin
                    estado_d = IDLE;
                end
            endcase

            if (paso) begin
                if (terminal) begin
                    vuelta_d = vuelta_inc;
                    if (modo_q == MODO_PP) begin
                        // Turnaround: skip the end value so it is not repeated.
                        cnt_load  = 1'b1;
                        cnt_valor = dir_q ? (MAX_C - 1'b1) : WC'(1);
                        dir_d     = ~dir_q;
                    end else begin
                        cnt_enable = 1'b1;
                    end
                    if (vuelta_inc == vueltas_q) estado_d = FIN;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
        end
    end

    assign busy       = (estado_q != IDLE);
    assign done       = (estado_q == FIN);
    assign dir        = dir_q;
    assign vuelta     = vuelta_q;
    assign fin_cuenta = terminal;
    assign estado     = estado_q;

endmodule
